// File: rtl/systolic_array_pkg.sv
// Shared defaults and latency helper for the output-stationary systolic multiplier.
package systolic_pkg;

   localparam int N_DEF   = 16;
   localparam int DIM_DEF = 3;

   // Edges from the start edge until the last PE holds its final sum.
   function automatic int total_latency(input int acol, input int arow, input int bcol);
      return acol + arow + bcol - 2;
   endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// One multiply-accumulate cell: registered A/B pass-through plus a 2N-bit accumulator.
// Build option SYSTOLIC_SIGNED_EN selects two's-complement operands instead of unsigned.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           en,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   output logic [N-1:0]   a_out,
   output logic [N-1:0]   b_out,
   output logic [2*N-1:0] acc
);

   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [2*N-1:0] prod;

`ifdef SYSTOLIC_SIGNED_EN
   // Low 2N bits of the sign-extended product equal the signed product mod 2^(2N).
   assign prod = {{N{a_in[N-1]}}, a_in} * {{N{b_in[N-1]}}, b_in};
`else
   assign prod = {{N{1'b0}}, a_in} * {{N{1'b0}}, b_in};
`endif

   always_comb begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = acc_q;
      if (clr) begin
         // A restart must also flush operands still travelling through the grid.
         a_d   = '0;
         b_d   = '0;
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + prod;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

endmodule

// File: rtl/systolic_array.sv
// Output-stationary AROW x BCOL systolic matrix multiplier, C = A x B, started by a valid pulse.
// Optional build macro SYSTOLIC_SIGNED_EN switches the PEs to signed arithmetic.
module systolic_array
   import systolic_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int AROW = DIM_DEF,
   parameter int ACOL = DIM_DEF,
   parameter int BROW = DIM_DEF,
   parameter int BCOL = DIM_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  valid,
   input  logic [AROW-1:0][ACOL-1:0][N-1:0]      a,
   input  logic [BROW-1:0][BCOL-1:0][N-1:0]      b,
   output logic [AROW-1:0][BCOL-1:0][2*N-1:0]    sys_array
);

   localparam int LAT = total_latency(ACOL, AROW, BCOL);
   localparam int CW  = $clog2(LAT + 1);

   if (BROW != ACOL) begin : g_dim_check
      $error("systolic_array: BROW must equal ACOL");
   end

   logic [AROW-1:0][ACOL-1:0][N-1:0] a_q, a_d;
   logic [BROW-1:0][BCOL-1:0][N-1:0] b_q, b_d;
   logic [CW-1:0]                    cnt_q, cnt_d;
   logic                             busy;

   logic [AROW-1:0][N-1:0] a_feed;
   logic [BCOL-1:0][N-1:0] b_feed;

   logic [N-1:0] a_h [AROW][BCOL+1];
   logic [N-1:0] b_v [AROW+1][BCOL];

   // cnt_q = t while cycle t after the start edge is in progress; 0 means idle.
   assign busy = (cnt_q != '0);

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      if (valid) begin
         a_d   = a;
         b_d   = b;
         cnt_d = CW'(1);
      end else if (busy) begin
         cnt_d = (cnt_q == CW'(LAT)) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
      end
   end

   // Row i / column j is skewed by its index: element k enters during cycle t = k + index + 1.
   always_comb begin
      a_feed = '0;
      b_feed = '0;
      for (int i = 0; i < AROW; i++) begin
         for (int k = 0; k < ACOL; k++) begin
            if (cnt_q == CW'(i + k + 1)) a_feed[i] = a_q[i][k];
         end
      end
      for (int j = 0; j < BCOL; j++) begin
         for (int k = 0; k < BROW; k++) begin
            if (cnt_q == CW'(j + k + 1)) b_feed[j] = b_q[k][j];
         end
      end
   end

   for (genvar i = 0; i < AROW; i++) begin : g_a_edge
      assign a_h[i][0] = a_feed[i];
   end

   for (genvar j = 0; j < BCOL; j++) begin : g_b_edge
      assign b_v[0][j] = b_feed[j];
   end

   for (genvar i = 0; i < AROW; i++) begin : g_row
      for (genvar j = 0; j < BCOL; j++) begin : g_col
         systolic_pe #(.N(N)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (valid),
            .en    (busy),
            .a_in  (a_h[i][j]),
            .b_in  (b_v[i][j]),
            .a_out (a_h[i][j+1]),
            .b_out (b_v[i+1][j]),
            .acc   (sys_array[i][j])
         );
      end
   end

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: table of matrix products plus restart/reset sequences,
// checked edge by edge against a partial-sum matrix model.
module tb_systolic_array;

   localparam int N    = 16;
   localparam int AROW = 3;
   localparam int ACOL = 3;
   localparam int BROW = 3;
   localparam int BCOL = 3;
   localparam int LAT  = ACOL + AROW + BCOL - 2;
   localparam int NVEC = 7;

   typedef logic [AROW-1:0][ACOL-1:0][N-1:0]   mat_a_t;
   typedef logic [BROW-1:0][BCOL-1:0][N-1:0]   mat_b_t;
   typedef logic [AROW-1:0][BCOL-1:0][2*N-1:0] mat_c_t;

   typedef struct {
      mat_a_t a;
      mat_b_t b;
      mat_c_t c;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst;
   logic   valid;
   mat_a_t a_i;
   mat_b_t b_i;
   mat_c_t sys_array;

   int n_vec = 0;
   int n_err = 0;

   vec_t tbl [NVEC];

   systolic_array #(.N(N), .AROW(AROW), .ACOL(ACOL), .BROW(BROW), .BCOL(BCOL)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .a         (a_i),
      .b         (b_i),
      .sys_array (sys_array)
   );

   always #5 clk = ~clk;

   function automatic logic [2*N-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y);
      longint p;
`ifdef SYSTOLIC_SIGNED_EN
      p = longint'($signed(x)) * longint'($signed(y));
`else
      p = longint'(x) * longint'(y);
`endif
      return p[2*N-1:0];
   endfunction

   // C element (i,j) after m edges: term k lands on edge i+j+k+1.
   function automatic mat_c_t partial(input mat_a_t a, input mat_b_t b, input int m);
      mat_c_t c;
      c = '0;
      for (int i = 0; i < AROW; i++)
         for (int j = 0; j < BCOL; j++)
            for (int k = 0; k < ACOL; k++)
               if (i + j + k + 1 <= m) c[i][j] = c[i][j] + mul(a[i][k], b[k][j]);
      return c;
   endfunction

   function automatic mat_a_t fill_a(input logic [N-1:0] v);
      mat_a_t m;
      for (int r = 0; r < AROW; r++) for (int c = 0; c < ACOL; c++) m[r][c] = v;
      return m;
   endfunction

   function automatic mat_b_t fill_b(input logic [N-1:0] v);
      mat_b_t m;
      for (int r = 0; r < BROW; r++) for (int c = 0; c < BCOL; c++) m[r][c] = v;
      return m;
   endfunction

   function automatic mat_c_t fill_c(input logic [2*N-1:0] v);
      mat_c_t m;
      for (int r = 0; r < AROW; r++) for (int c = 0; c < BCOL; c++) m[r][c] = v;
      return m;
   endfunction

   task automatic check_mat(input string name, input mat_c_t exp);
      n_vec++;
      if (sys_array !== exp) begin
         n_err++;
         $display("FAIL %s: sys_array=%h expected=%h", name, sys_array, exp);
      end
   endtask

   // Leaves time just after the start edge T0, with valid dropped and inputs scrambled.
   task automatic do_start(input mat_a_t a, input mat_b_t b);
      @(negedge clk);
      valid = 1'b1;
      a_i   = a;
      b_i   = b;
      @(posedge clk);
      #1;
      valid = 1'b0;
      a_i   = mat_a_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      b_i   = mat_b_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic run_checks(input string name, input mat_a_t a, input mat_b_t b, input int nedges);
      for (int m = 1; m <= nedges; m++) begin
         @(posedge clk);
         #1;
         check_mat($sformatf("%s_edge%0d", name, m), partial(a, b, m));
      end
   endtask

   task automatic check_zero_edges(input string name, input int nedges);
      for (int m = 1; m <= nedges; m++) begin
         @(posedge clk);
         #1;
         check_mat($sformatf("%s_zero%0d", name, m), '0);
      end
   endtask

   initial begin
      mat_a_t ra;
      mat_b_t rb;

      tbl[0].a = fill_a(16'd11);
      tbl[0].b = fill_b(16'd12);
      tbl[0].c = fill_c(32'd396);

      tbl[1].a = '0;
      for (int r = 0; r < AROW; r++) tbl[1].a[r][r] = 16'd1;
      for (int r = 0; r < BROW; r++)
         for (int c = 0; c < BCOL; c++) begin
            tbl[1].b[r][c] = 16'(r * BCOL + c + 1);
            tbl[1].c[r][c] = 32'(r * BCOL + c + 1);
         end

      tbl[2].a = fill_a(16'hFFFF);
      tbl[2].b = fill_b(16'hFFFF);
`ifdef SYSTOLIC_SIGNED_EN
      tbl[2].c = fill_c(32'd3);
`else
      tbl[2].c = fill_c(32'hFFFA0003);
`endif

      for (int v = 3; v < NVEC; v++) begin
         for (int r = 0; r < AROW; r++)
            for (int c = 0; c < ACOL; c++) tbl[v].a[r][c] = 16'($urandom_range(0, 65535));
         for (int r = 0; r < BROW; r++)
            for (int c = 0; c < BCOL; c++) tbl[v].b[r][c] = 16'($urandom_range(0, 65535));
         tbl[v].c = partial(tbl[v].a, tbl[v].b, LAT);
      end

      rst   = 1'b1;
      valid = 1'b0;
      a_i   = '0;
      b_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_mat("reset_state", '0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < NVEC; v++) begin
         do_start(tbl[v].a, tbl[v].b);
         run_checks($sformatf("vec%0d", v), tbl[v].a, tbl[v].b, LAT + 10);
         check_mat($sformatf("vec%0d_final", v), tbl[v].c);
      end

      do_start(fill_a(16'd11), fill_b(16'd12));
      run_checks("restart_old", fill_a(16'd11), fill_b(16'd12), 2);
      do_start(fill_a(16'd2), fill_b(16'd5));
      run_checks("restart_new", fill_a(16'd2), fill_b(16'd5), LAT + 3);
      check_mat("restart_final", fill_c(32'd30));

      @(negedge clk);
      valid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         for (int r = 0; r < AROW; r++)
            for (int c = 0; c < ACOL; c++) ra[r][c] = 16'($urandom_range(0, 65535));
         for (int r = 0; r < BROW; r++)
            for (int c = 0; c < BCOL; c++) rb[r][c] = 16'($urandom_range(0, 65535));
         a_i = ra;
         b_i = rb;
         @(posedge clk);
         #1;
         check_mat($sformatf("held_valid_clear%0d", s), '0);
      end
      valid = 1'b0;
      run_checks("held_valid", ra, rb, LAT + 2);
      check_mat("held_valid_final", partial(ra, rb, LAT));

      do_start(fill_a(16'd11), fill_b(16'd12));
      run_checks("mid_reset_run", fill_a(16'd11), fill_b(16'd12), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_mat("mid_reset_edge", '0);
      @(negedge clk);
      rst = 1'b0;
      check_zero_edges("mid_reset_after", LAT + 3);

      do_start(tbl[0].a, tbl[0].b);
      run_checks("pre_rstvalid", tbl[0].a, tbl[0].b, LAT);
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b1;
      a_i   = fill_a(16'd7);
      b_i   = fill_b(16'd9);
      @(posedge clk);
      #1;
      check_mat("rst_valid_edge", '0);
      @(negedge clk);
      rst   = 1'b0;
      valid = 1'b0;
      check_zero_edges("rst_valid_after", LAT + 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- Output-stationary systolic matrix multiplier. Computes C = A × B, with A of size AROW×ACOL and B of size BROW×BCOL, on one valid pulse.
- A rows stream left→right and B columns stream top→bottom through an AROW×BCOL grid of multiply-accumulate PEs. Each PE owns one element of C.
- Used as the matrix-multiply core of the neural-network datapath.
- Results stay on `sys_array` until the next start or reset.

Parameters:
- N, 16, operand element width in bits; results are 2*N bits.
- AROW, 3, rows of A and of C.
- ACOL, 3, columns of A (inner dimension).
- BROW, 3, rows of B; must equal ACOL, otherwise elaboration fails via $error.
- BCOL, 3, columns of B and of C.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  start strobe; A and B are sampled on a clk edge where valid=1.
- a  input  [AROW-1:0][ACOL-1:0][N-1:0]  matrix A, packed, a[row][col].
- b  input  [BROW-1:0][BCOL-1:0][N-1:0]  matrix B, packed, b[row][col].
- sys_array  output  [AROW-1:0][BCOL-1:0][2*N-1:0]  matrix C, c[row][col]; driven directly from the PE accumulators.

Behaviour:
- Reset (sampled at a clk edge with rst=1):
  - all accumulators, skew registers and the sequencer counter go to 0, so sys_array=0.
  - rst has priority over valid.
- Start:
  - Call edge T0 a clk edge with valid=1 and rst=0.
  - At T0 the block captures a and b into internal registers, clears every accumulator to 0 and starts the sequencer.
  - After T0, the a/b inputs are don't-care.
- Skewing:
  - Row i of A enters the grid delayed by i cycles; column j of B enters delayed by j cycles.
  - Operands move one PE per cycle: A values to the right, B values downward. Zero bubbles are injected outside the valid window.
- Cycle-exact accumulation:
  - At edge T0+t (t≥1), PE(i,j) does acc += a[i][k]*b[k][j], where k = t-1-i-j, only when 0 ≤ k < ACOL.
  - PE(i,j) is final after edge T0+ACOL+i+j.
  - The whole array is final after edge T0+ACOL+AROW+BCOL-2, i.e. 7 cycles for 3×3.
- Partial sums are visible on sys_array while computing; consumers wait for the full latency.
- Arithmetic:
  - unsigned; the N×N product is a full 2N bits.
  - Accumulation is modulo 2^(2N), with silent wrap and no saturation.
- Hold: after completion the outputs and accumulators are frozen until the next start or reset.
- valid asserted while busy: restart. The new operands are captured, accumulators are cleared at that edge, and the in-flight computation is discarded.
- valid held high for multiple cycles: each edge restarts. Only the last sampled operands produce the final result, at the full latency after the last valid edge.
- Reset mid-operation: everything clears at that edge and there is no later output activity.

Optional Feature:
- Macro SYSTOLIC_SIGNED_EN.
- When defined:
  - operands are two's-complement signed N-bit values.
  - products are sign-extended to 2N bits and accumulated signed, still wrapping modulo 2^(2N).
- When undefined: unsigned arithmetic, as above.
- Port list is identical in both builds.

Decomposition:
- Package systolic_pkg:
  - default-parameter localparams (N_DEF=16, DIM_DEF=3).
  - a function computing total latency (ACOL+AROW+BCOL-2).
- Sub-module systolic_pe:
  - inputs: clk, rst, clr, a_in, b_in, en.
  - outputs: a_out, b_out (registered pass-through) and acc[2N-1:0].
- Top level: instantiates the AROW×BCOL PE grid through generate loops, plus the skew/feed sequencer.

Test Plan:
- All a=11, all b=12; valid for one cycle → every sys_array element = 396 (0x18C), all final 7 edges after T0; value held 10+ cycles.
- A = identity, B = [1..9] row-major → sys_array equals B. Check c[0][0] is final at T0+3 and c[2][2] at T0+7.
- All a = all b = 0xFFFF → each element = 0xFFFA0003 (wrap mod 2^32). With SYSTOLIC_SIGNED_EN → each element = 3.
- Start with all 11/12, then at T0+3 re-assert valid with all a=2, b=5 → final elements = 30 at T0+3+7; no residue of 396.
- Start with all 11/12, then assert rst at T0+2 → sys_array = 0 from that edge on, and stays 0 with valid=0.
- Reset with valid=1 on the same edge → sys_array stays 0 and no computation starts.
